// File: rtl/fb_pixel_fetch.sv
// Frame-buffer readout stage: turns scaled coordinates into BRAM read addresses for a
// double-buffered frame store, then returns pixels aligned with the delayed video timing.
module fb_pixel_fetch #(
   parameter int FB_WIDTH     = 240,
   parameter int FB_HEIGHT    = 320,
   parameter int PIXEL_WIDTH  = 16,
   parameter int ADDR_WIDTH   = 18,
   parameter int BRAM_LATENCY = 2,
   parameter logic [PIXEL_WIDTH-1:0] BORDER_COLOR = '0
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [10:0]            scaled_hcount_in,
   input  logic [9:0]             scaled_vcount_in,
   input  logic                   valid_addr_in,
   input  logic                   hsync_in,
   input  logic                   vsync_in,
   input  logic                   blank_in,
   input  logic                   swap_req_in,
   output logic [ADDR_WIDTH-1:0]  bram_addr_out,
   input  logic [PIXEL_WIDTH-1:0] bram_data_in,
   output logic [PIXEL_WIDTH-1:0] pixel_out,
   output logic                   hsync_out,
   output logic                   vsync_out,
   output logic                   blank_out,
   output logic                   write_buf_out,
   output logic                   swap_pending_out,
   output logic                   swap_done_out,
   output logic [15:0]            frame_count_out
);

   localparam logic [ADDR_WIDTH-1:0] FB_W_A    = ADDR_WIDTH'(FB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] FB_SIZE_A = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT);
   localparam logic [10:0]           H_LIM     = 11'(FB_WIDTH);
   localparam logic [9:0]            V_LIM     = 10'(FB_HEIGHT);

   function automatic logic [ADDR_WIDTH-1:0] pixel_offset(input logic [10:0] h,
                                                          input logic [9:0]  v);
      logic [ADDR_WIDTH-1:0] h_ext;
      logic [ADDR_WIDTH-1:0] v_ext;
      h_ext = ADDR_WIDTH'(h);
      v_ext = ADDR_WIDTH'(v);
      return v_ext * FB_W_A + h_ext;
   endfunction

   logic                  disp_buf;
   logic                  pending;
   logic                  vsync_prev;
   logic                  vs_rise;
   logic                  take_swap;

   logic                  addr_ok;
   logic [ADDR_WIDTH-1:0] buf_base;
   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] addr_next;

   logic                  hs_p0;
   logic                  vs_p0;
   logic                  bl_p0;
   logic                  vld_p0;

   logic [BRAM_LATENCY-1:0] hs_p1;
   logic [BRAM_LATENCY-1:0] vs_p1;
   logic [BRAM_LATENCY-1:0] bl_p1;
   logic [BRAM_LATENCY-1:0] vld_p1;

   // Buffer swap control
   always_comb begin
      vs_rise   = vsync_in && !vsync_prev;
      take_swap = vs_rise && (pending || swap_req_in);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         disp_buf        <= 1'b0;
         pending         <= 1'b0;
         vsync_prev      <= 1'b0;
         swap_done_out   <= 1'b0;
         frame_count_out <= 16'h0000;
      end else begin
         vsync_prev    <= vsync_in;
         swap_done_out <= take_swap;
         if (take_swap) begin
            disp_buf <= ~disp_buf;
            pending  <= 1'b0;
         end else if (swap_req_in) begin
            pending <= 1'b1;
         end
         if (vs_rise)
            frame_count_out <= frame_count_out + 16'd1;
      end
   end

   assign write_buf_out    = ~disp_buf;
   assign swap_pending_out = pending;

   // Stage A: address generation; out-of-range coordinates collapse onto the buffer base
   always_comb begin
      addr_ok   = valid_addr_in && (scaled_hcount_in < H_LIM) && (scaled_vcount_in < V_LIM);
      buf_base  = disp_buf ? FB_SIZE_A : '0;
      offset    = addr_ok ? pixel_offset(scaled_hcount_in, scaled_vcount_in) : '0;
      addr_next = buf_base + offset;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bram_addr_out <= '0;
         hs_p0         <= 1'b0;
         vs_p0         <= 1'b0;
         bl_p0         <= 1'b1;
         vld_p0        <= 1'b0;
      end else begin
         bram_addr_out <= addr_next;
         hs_p0         <= hsync_in;
         vs_p0         <= vsync_in;
         bl_p0         <= blank_in;
         vld_p0        <= addr_ok;
      end
   end

   // Stage B: timing/valid delay matching the BRAM read latency
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hs_p1  <= '0;
         vs_p1  <= '0;
         bl_p1  <= '1;
         vld_p1 <= '0;
      end else begin
         hs_p1[0]  <= hs_p0;
         vs_p1[0]  <= vs_p0;
         bl_p1[0]  <= bl_p0;
         vld_p1[0] <= vld_p0;
         for (int i = 1; i < BRAM_LATENCY; i++) begin
            hs_p1[i]  <= hs_p1[i-1];
            vs_p1[i]  <= vs_p1[i-1];
            bl_p1[i]  <= bl_p1[i-1];
            vld_p1[i] <= vld_p1[i-1];
         end
      end
   end

   // Output stage: pixel select and final timing register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pixel_out <= '0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         blank_out <= 1'b1;
      end else begin
         pixel_out <= (vld_p1[BRAM_LATENCY-1] && !bl_p1[BRAM_LATENCY-1]) ? bram_data_in
                                                                          : BORDER_COLOR;
         hsync_out <= hs_p1[BRAM_LATENCY-1];
         vsync_out <= vs_p1[BRAM_LATENCY-1];
         blank_out <= bl_p1[BRAM_LATENCY-1];
      end
   end

endmodule
